mult_error_sweeper: RTL and testbench
=====================================

// Module: mult_error_sweeper
// PURPOSE
// Exhaustive accuracy evaluator for candidate WIDTH x WIDTH multipliers (RL-generated / corrected).
// Drives every operand pair into an external DUT multiplier and reads back its product.
// Compares each product against the exact product and accumulates error statistics.
// Streams one correction record per mismatching pair, used to build the {A,B} correction case tables.
// PARAMETERS
// WIDTH  2  operand width; product width is 2*WIDTH
// LAT    0  DUT latency in clk cycles from operand change to valid dut_p (0 = combinational DUT)
// PORTS
// clk          in   1          clock, rising edge
// rst          in   1          asynchronous reset, active-high
// start        in   1          begin sweep; sampled only in IDLE
// busy         out  1          high from the cycle after start is accepted until DONE
// done         out  1          one-cycle pulse in DONE
// op_a         out  WIDTH      operand A to DUT (registered)
// op_b         out  WIDTH      operand B to DUT (registered)
// dut_p        in   2*WIDTH    DUT product
// err_count    out  2*WIDTH+1  number of mismatching pairs in last/current sweep
// max_abs_err  out  2*WIDTH    max |dut_p - exact|
// err_sum      out  4*WIDTH    sum of |dut_p - exact|
// corr_valid   out  1          correction record valid
// corr_ready   in   1          consumer accepts record when corr_valid & corr_ready
// corr_a       out  WIDTH      record: operand A
// corr_b       out  WIDTH      record: operand B
// corr_exact   out  2*WIDTH    record: exact product (value for correction table)
// corr_dut     out  2*WIDTH    record: DUT product as observed
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; op_a/op_b = 0; statistics cleared. Reset mid-sweep aborts immediately, with no done.
// - Sweep order: index = {op_a, op_b}, from 0 to 2^(2*WIDTH)-1; op_b is the LSB.
// - FSM IDLE -> (start) SETTLE -> CHECK -> [EMIT] -> SETTLE or DONE -> IDLE.
// - On start acceptance: statistics cleared, index = 0, and operands driven from the next cycle.
// - SETTLE: lasts exactly LAT cycles after the operands update. It is skipped when LAT = 0.
// - CHECK: one cycle. exact = op_a*op_b at full 2*WIDTH width. diff = |dut_p - exact| at 2*WIDTH width, no wrap.
// - Mismatch (dut_p != exact): err_count+1, err_sum+=diff, max_abs_err=max(max_abs_err,diff); the record is registered; go to EMIT.
// - Match: no statistic change.
// - EMIT: corr_valid=1, record fields stable until handshake. Leave EMIT on the cycle corr_valid & corr_ready.
// - Backpressure stalls the sweep; the operands hold during the stall.
// - Advance: if index is last -> DONE, else index+1, new operands next cycle -> SETTLE/CHECK.
// - Timing with no mismatches and no stalls: done is high exactly 2^(2*WIDTH)*(LAT+1)+1 cycles after the start-accept edge.
// - DONE: done=1, busy=0 for one cycle -> IDLE.
// - Statistics and the final operands are held until the next accepted start.
// - start while busy or in DONE: ignored.
// - corr_ready is don't-care when corr_valid=0. corr_valid never asserts outside EMIT.
// - Statistic counters cannot overflow at the stated widths, so no saturation logic is needed.
// STRUCTURE
// - Shared package mult_eval_pkg holds:
//   - the state enum {IDLE, SETTLE, CHECK, EMIT, DONE};
//   - localparams PW=2*WIDTH, NPAIRS=1<<(2*WIDTH);
//   - the correction-record struct {a, b, exact, dut}.
// - One sub-module, mult_abs_diff: combinational exact product plus |dut_p - exact|.
// - Everything else (FSM, index/latency counters, stats, record register) stays in this module.
// TESTING
// 1. WIDTH=2, LAT=0, exact DUT, corr_ready=1, start -> err_count=0, max_abs_err=0, err_sum=0, corr_valid never high, done 17 cycles after accept.
// 2. WIDTH=2, LAT=0, DUT returns 0 only for 3*3 -> one record a=3,b=3,exact=9,dut=0; err_count=1, max_abs_err=9, err_sum=9.
// 3. Same DUT, corr_ready low 5 cycles during EMIT -> record and op_a/op_b stable throughout, done 5 cycles later than the no-stall case.
// 4. WIDTH=2, LAT=2, registered exact DUT -> err_count=0, done 49 cycles after accept (no false mismatches from latency).
// 5. rst pulsed at index 7 -> all outputs 0 asynchronously, no done; a new start sweeps from index 0 with cleared statistics.
// 6. start re-asserted while busy -> ignored; sweep results identical to scenario 1.

Source files
------------

// File: rtl/mult_error_sweeper_pkg.sv
// rtl/mult_error_sweeper_pkg.sv - shared types and sizes for the multiplier error sweeper
// Record sizes follow PKG_WIDTH; instantiate the sweeper with WIDTH == PKG_WIDTH.
package mult_eval_pkg;

  localparam int PKG_WIDTH = 2;
  localparam int PW        = 2 * PKG_WIDTH;
  localparam int NPAIRS    = 1 << PW;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    CHECK  = 3'd2,
    EMIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  typedef struct packed {
    logic [PKG_WIDTH-1:0] a;
    logic [PKG_WIDTH-1:0] b;
    logic [PW-1:0]        exact;
    logic [PW-1:0]        dut;
  } corr_rec_t;

endpackage

// File: rtl/mult_error_sweeper_if.sv
// rtl/mult_error_sweeper_if.sv - operand/product bus and correction-record stream
interface mult_error_sweeper_if #(parameter int WIDTH = 2);

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] dut_p;
  logic               corr_valid;
  logic               corr_ready;
  logic [WIDTH-1:0]   corr_a;
  logic [WIDTH-1:0]   corr_b;
  logic [2*WIDTH-1:0] corr_exact;
  logic [2*WIDTH-1:0] corr_dut;

  modport master (
    output op_a, op_b, corr_valid, corr_a, corr_b, corr_exact, corr_dut,
    input  dut_p, corr_ready
  );

  modport slave (
    input  op_a, op_b, corr_valid, corr_a, corr_b, corr_exact, corr_dut,
    output dut_p, corr_ready
  );

endinterface

// File: rtl/mult_error_sweeper_abs_diff.sv
// rtl/mult_error_sweeper_abs_diff.sv - exact product and absolute error of a candidate product
module mult_abs_diff
  import mult_eval_pkg::*;
#(
  parameter int WIDTH = PKG_WIDTH
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] p,
  output logic [2*WIDTH-1:0] exact,
  output logic [2*WIDTH-1:0] diff
);

  localparam int PROD_W = 2 * WIDTH;

  always_comb begin
    exact = PROD_W'(a) * PROD_W'(b);
    diff  = (p >= exact) ? (p - exact) : (exact - p);
  end

endmodule

// File: rtl/mult_error_sweeper.sv
// rtl/mult_error_sweeper.sv - exhaustive sweep of a WIDTH x WIDTH multiplier with error stats
// Index {op_a, op_b} walks every pair; mismatches are counted and streamed as records.
module mult_error_sweeper
  import mult_eval_pkg::*;
#(
  parameter int WIDTH = PKG_WIDTH,
  parameter int LAT   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH:0]     err_count,
  output logic [2*WIDTH-1:0]   max_abs_err,
  output logic [4*WIDTH-1:0]   err_sum,
  mult_error_sweeper_if.master bus
);

  localparam int PROD_W = 2 * WIDTH;
  localparam int SUM_W  = 4 * WIDTH;
  localparam int CNT_W  = (LAT > 1) ? $clog2(LAT + 1) : 1;
  localparam logic [PROD_W-1:0] LAST_IDX = '1;

  state_t            state;
  logic [PROD_W-1:0] idx;
  logic [CNT_W-1:0]  lat_cnt;
  corr_rec_t         rec;
  logic [PROD_W-1:0] exact;
  logic [PROD_W-1:0] diff;
  logic              mismatch;
  logic              advance;

  mult_abs_diff #(.WIDTH(WIDTH)) u_abs_diff (
    .a     (bus.op_a),
    .b     (bus.op_b),
    .p     (bus.dut_p),
    .exact (exact),
    .diff  (diff)
  );

  assign mismatch = (bus.dut_p != exact);
  assign advance  = ((state == CHECK) && !mismatch) || ((state == EMIT) && bus.corr_ready);

  // The first pair always gets one settle cycle beyond LAT while the operands leave their held value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      lat_cnt     <= '0;
      err_count   <= '0;
      max_abs_err <= '0;
      err_sum     <= '0;
      rec         <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state       <= SETTLE;
          idx         <= '0;
          lat_cnt     <= CNT_W'(LAT);
          err_count   <= '0;
          max_abs_err <= '0;
          err_sum     <= '0;
        end
        SETTLE: begin
          if (lat_cnt == '0) state <= CHECK;
          else               lat_cnt <= lat_cnt - 1'b1;
        end
        CHECK: if (mismatch) begin
          err_count   <= err_count + 1'b1;
          err_sum     <= err_sum + SUM_W'(diff);
          max_abs_err <= (diff > max_abs_err) ? diff : max_abs_err;
          rec         <= '{a: bus.op_a, b: bus.op_b, exact: exact, dut: bus.dut_p};
          state       <= EMIT;
        end
        EMIT:    ;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (advance) begin
        if (idx == LAST_IDX) begin
          state <= DONE;
        end else begin
          idx <= idx + 1'b1;
          if (LAT == 0) begin
            state <= CHECK;
          end else begin
            state   <= SETTLE;
            lat_cnt <= CNT_W'(LAT - 1);
          end
        end
      end
    end
  end

  assign busy           = (state == SETTLE) || (state == CHECK) || (state == EMIT);
  assign done           = (state == DONE);
  assign bus.op_a       = idx[PROD_W-1:WIDTH];
  assign bus.op_b       = idx[WIDTH-1:0];
  assign bus.corr_valid = (state == EMIT);
  assign bus.corr_a     = rec.a;
  assign bus.corr_b     = rec.b;
  assign bus.corr_exact = rec.exact;
  assign bus.corr_dut   = rec.dut;

endmodule

// File: tb/tb_mult_error_sweeper.sv
// tb/tb_mult_error_sweeper.sv - scoreboard bench for mult_error_sweeper
module tb_mult_error_sweeper;
  import mult_eval_pkg::*;

  localparam int W = 2;

  typedef struct {
    int a;
    int b;
    int exact;
    int dut;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           start0 = 1'b0, busy0, done0;
  logic [2*W:0]   ec0;
  logic [2*W-1:0] mx0;
  logic [4*W-1:0] es0;
  logic           start2 = 1'b0, busy2, done2;
  logic [2*W:0]   ec2;
  logic [2*W-1:0] mx2;
  logic [4*W-1:0] es2;
  logic [2*W-1:0] p2_r1, p2_r2;

  int   mode = 0;
  int   total = 0;
  int   bad = 0;
  rec_t q[$];

  mult_error_sweeper_if #(.WIDTH(W)) ifc0 ();
  mult_error_sweeper_if #(.WIDTH(W)) ifc2 ();

  mult_error_sweeper #(.WIDTH(W), .LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .err_count(ec0), .max_abs_err(mx0), .err_sum(es0), .bus(ifc0.master)
  );

  mult_error_sweeper #(.WIDTH(W), .LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .err_count(ec2), .max_abs_err(mx2), .err_sum(es2), .bus(ifc2.master)
  );

  function automatic logic [2*W-1:0] model_p(input logic [W-1:0] a, input logic [W-1:0] b, input int m);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    if (m == 1 && a == 2'd3 && b == 2'd3) p = '0;
    if (m == 2 && a == 2'd1) p = p + 1'b1;
    return p;
  endfunction

  assign ifc0.dut_p = model_p(ifc0.op_a, ifc0.op_b, mode);

  // Candidate with two register stages: exact but LAT = 2.
  always @(posedge clk) begin
    p2_r1 <= {{W{1'b0}}, ifc2.op_a} * {{W{1'b0}}, ifc2.op_b};
    p2_r2 <= p2_r1;
  end
  assign ifc2.dut_p = p2_r2;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ifc0.corr_valid) begin
      if (q.size() == 0) begin
        check("rec_unexpected", 1, 0);
      end else begin
        check("rec_a", ifc0.corr_a, q[0].a);
        check("rec_b", ifc0.corr_b, q[0].b);
        check("rec_exact", ifc0.corr_exact, q[0].exact);
        check("rec_dut", ifc0.corr_dut, q[0].dut);
        check("rec_ops_hold", {ifc0.op_a, ifc0.op_b}, q[0].a * 4 + q[0].b);
        if (ifc0.corr_ready) void'(q.pop_front());
      end
    end
    if (!rst && ifc2.corr_valid) check("rec2_unexpected", 1, 0);
  end

  task automatic build_exp(input int m, output int cnt, output int sum, output int mx);
    rec_t r;
    cnt = 0; sum = 0; mx = 0;
    for (int i = 0; i < NPAIRS; i++) begin
      r.a     = i >> W;
      r.b     = i % (1 << W);
      r.exact = r.a * r.b;
      r.dut   = int'(model_p(W'(r.a), W'(r.b), m));
      if (r.dut != r.exact) begin
        int d;
        d = (r.dut > r.exact) ? r.dut - r.exact : r.exact - r.dut;
        cnt++;
        sum += d;
        if (d > mx) mx = d;
        q.push_back(r);
      end
    end
  endtask

  task automatic sweep0(input int m, input int stall, input bit poke, input string tag);
    int n, ecnt, esum, emax, stall_left;
    bit seen;
    mode = m;
    build_exp(m, ecnt, esum, emax);
    stall_left = stall;
    @(negedge clk) start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) check({tag, "_first_idx"}, {ifc0.op_a, ifc0.op_b}, 0);
      if (poke) start0 = (n == 5 || n == 6);
      if (ifc0.corr_valid && stall_left > 0) begin
        ifc0.corr_ready = 1'b0;
        stall_left--;
      end else begin
        ifc0.corr_ready = 1'b1;
      end
      if (done0) begin
        seen = 1'b1;
        check({tag, "_busy_in_done"}, busy0, 0);
        if (poke) start0 = 1'b1;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, n, NPAIRS + 1 + ecnt + stall);
    check({tag, "_err_count"}, ec0, ecnt);
    check({tag, "_max_abs_err"}, mx0, emax);
    check({tag, "_err_sum"}, es0, esum);
    check({tag, "_records_left"}, q.size(), 0);
    @(posedge clk);
    #1 start0 = 1'b0;
    check({tag, "_idle_after"}, {busy0, done0}, 0);
    ifc0.corr_ready = 1'b1;
    q.delete();
  endtask

  initial begin
    int n, ecnt, esum, emax;
    bit seen;
    ifc0.corr_ready = 1'b1;
    ifc2.corr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_ops", {ifc0.op_a, ifc0.op_b}, 0);
    check("rst_stats", {ec0, mx0, es0}, 0);
    check("rst_corr_valid", ifc0.corr_valid, 0);
    @(negedge clk) rst = 1'b0;

    sweep0(0, 0, 1'b0, "s1");
    sweep0(1, 0, 1'b0, "s2");
    sweep0(1, 5, 1'b0, "s3");

    @(negedge clk) start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(posedge clk);
      n++;
      #1;
      if (done2) seen = 1'b1;
    end
    check("s4_done_seen", seen, 1);
    check("s4_latency", n, NPAIRS * 3 + 1);
    check("s4_err_count", ec2, 0);
    check("s4_err_sum", es2, 0);

    mode = 2;
    build_exp(2, ecnt, esum, emax);
    @(negedge clk) start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    n = 0;
    while ({ifc0.op_a, ifc0.op_b} != 4'd7 && n < 400) begin
      @(posedge clk);
      n++;
      #1;
    end
    check("s5_reached_7", {ifc0.op_a, ifc0.op_b}, 7);
    check("s5_pre_rst_count", ec0, 3);
    #1 rst = 1'b1;
    #1;
    check("s5_async_busy", busy0, 0);
    check("s5_async_ops", {ifc0.op_a, ifc0.op_b}, 0);
    check("s5_async_stats", {ec0, mx0, es0}, 0);
    check("s5_async_corr_valid", ifc0.corr_valid, 0);
    q.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check("s5_no_done", done0, 0);
    end
    @(negedge clk) rst = 1'b0;
    sweep0(0, 0, 1'b0, "s5");

    sweep0(0, 0, 1'b1, "s6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
